cmp_result_monitor: RTL and testbench
=====================================

// Module: cmp_result_monitor
// PURPOSE
//   Downstream consumer of the 4-bit comparator flags (lt, gr, eq). On each valid
//   sample it counts comparison outcomes, detects a run of consecutive "equal"
//   results (match lock) and flags illegal flag combinations. Its registered
//   status feeds the lab datapath's control/display logic.
// PARAMETERS
//   CNT_W      8  width of each outcome counter; counters saturate at 2**CNT_W-1
//   STREAK_LEN 4  consecutive valid eq samples needed to assert match_lock (>=1)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      lt/gr/eq carry a sample this cycle
//   lt         in   1      comparator A<B
//   gr         in   1      comparator A>B
//   eq         in   1      comparator A==B
//   clr        in   1      synchronous clear of counters, err and streak FSM
//   lt_cnt     out  CNT_W  number of valid lt samples since reset/clr
//   gr_cnt     out  CNT_W  number of valid gr samples since reset/clr
//   eq_cnt     out  CNT_W  number of valid eq samples since reset/clr
//   match_lock out  1      high while the FSM is in LOCKED
//   err        out  1      sticky: an in_valid sample was not one-hot
// BEHAVIOUR
//   - Reset (rst=1, asynchronous): all counters 0, err=0, match_lock=0, FSM=IDLE,
//     streak counter 0. Reset mid-run discards all state immediately.
//   - All outputs are registered. A sample presented at edge k is reflected on
//     the outputs after edge k (1-cycle latency).
//   - Legal sample: in_valid=1 and exactly one of {lt,gr,eq} is 1.
//   - Illegal sample: in_valid=1 and zero, two or three flags set. err<=1, no
//     counter changes, FSM and streak hold.
//   - in_valid=0: everything holds. Flag values are ignored.
//   - Counters: increment the counter matching a legal sample by 1. Saturate at
//     all-ones with no wrap; a saturated counter stays saturated until clr/rst.
//   - Streak FSM (streak counter width = clog2(STREAK_LEN+1)):
//       IDLE   : legal eq -> streak=1; go to LOCKED if STREAK_LEN==1, else TRACK.
//                Legal lt/gr -> stay in IDLE.
//       TRACK  : legal eq -> streak+1; on reaching STREAK_LEN go to LOCKED.
//                Legal lt/gr -> streak=0, go to IDLE.
//       LOCKED : legal eq -> stay; streak holds at STREAK_LEN.
//                Legal lt/gr -> streak=0, go to IDLE (match_lock drops next cycle).
//     Illegal samples and idle cycles never break or extend the streak.
//   - clr=1: counters=0, err=0, streak=0, FSM=IDLE. clr takes priority over a
//     sample in the same cycle, which is discarded (not counted).
//   - err is cleared only by clr or rst.
// TESTING
//   1 Reset: assert rst mid-stream with counts nonzero -> all outputs 0 right
//     away, without waiting for a clock edge.
//   2 Sequence A=5/B=7 (lt), A=10/B=7 (gr), A=10/B=10 (eq), one per cycle
//     -> lt_cnt=1, gr_cnt=1, eq_cnt=1, match_lock=0, err=0.
//   3 Four consecutive legal eq samples with STREAK_LEN=4 -> match_lock rises
//     the cycle after the 4th. A gap with in_valid=0 inside the run does not
//     break it. A following lt sample -> match_lock=0 the next cycle.
//   4 Samples with in_valid=1, lt=1, eq=1, then all flags 0 -> err=1, all
//     counters unchanged, FSM unchanged. Then clr=1 -> err=0.
//   5 CNT_W=2, five legal gr samples -> gr_cnt=3 (saturated, no wrap to 0).
//   6 clr=1 together with a legal eq in the same cycle -> eq_cnt=0, FSM=IDLE
//     (sample dropped).

Source files
------------

// File: rtl/cmp_result_monitor.sv
// cmp_result_monitor
//   Consumes the lt/gr/eq flags of a magnitude comparator. Each valid sample
//   is classified as legal (exactly one flag set) or illegal. Legal samples
//   bump a saturating per-outcome counter and drive a streak FSM that raises
//   match_lock after STREAK_LEN consecutive legal eq samples. Illegal samples
//   set a sticky err and change nothing else. All status is registered, with a
//   1-cycle latency from the sampling edge.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no eq run in progress, streak = 0
//   TRACK  | eq run in progress, 1 <= streak < STREAK_LEN
//   LOCKED | STREAK_LEN consecutive eq seen, match_lock = 1
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid        lt/gr/eq carry a sample this cycle
//   lt, gr, eq      comparator flags
//   clr             synchronous clear; wins over a same-cycle sample
//   lt_cnt/gr_cnt/eq_cnt  saturating outcome counters
//   match_lock      high while in LOCKED
//   err             sticky flag for a non-one-hot valid sample
module cmp_result_monitor #(
  parameter int CNT_W      = 8,
  parameter int STREAK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             lt,
  input  logic             gr,
  input  logic             eq,
  input  logic             clr,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] gr_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic             match_lock,
  output logic             err
);

  localparam int SW = $clog2(STREAK_LEN + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [SW-1:0]    STREAK_END = SW'(STREAK_LEN);
  localparam logic [SW-1:0]    STREAK_ONE = SW'(1);

  logic [1:0]    state;
  logic [SW-1:0] streak;
  logic          one_hot;
  logic          legal;
  logic          illegal;

  // Odd parity excludes 0 and 2 flags set; the AND term excludes all three.
  assign one_hot = (lt ^ gr ^ eq) & ~(lt & gr & eq);
  assign legal   = in_valid & one_hot;
  assign illegal = in_valid & ~one_hot;

  assign match_lock = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lt_cnt <= '0;
      gr_cnt <= '0;
      eq_cnt <= '0;
      err    <= 1'b0;
    end else if (clr) begin
      lt_cnt <= '0;
      gr_cnt <= '0;
      eq_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (illegal) err <= 1'b1;
      if (legal && lt && lt_cnt != CNT_MAX) lt_cnt <= lt_cnt + 1'b1;
      if (legal && gr && gr_cnt != CNT_MAX) gr_cnt <= gr_cnt + 1'b1;
      if (legal && eq && eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      streak <= '0;
    end else if (clr) begin
      state  <= IDLE;
      streak <= '0;
    end else if (legal) begin
      case (state)
        IDLE: begin
          if (eq) begin
            streak <= STREAK_ONE;
            state  <= (STREAK_LEN == 1) ? LOCKED : TRACK;
          end
        end
        TRACK: begin
          if (eq) begin
            streak <= streak + 1'b1;
            if (streak + 1'b1 == STREAK_END) state <= LOCKED;
          end else begin
            streak <= '0;
            state  <= IDLE;
          end
        end
        LOCKED: begin
          if (!eq) begin
            streak <= '0;
            state  <= IDLE;
          end
        end
        default: begin
          streak <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_result_monitor.sv
module tb_cmp_result_monitor;

  localparam int STREAK_LEN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       lt = 1'b0;
  logic       gr = 1'b0;
  logic       eq = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] lt_cnt, gr_cnt, eq_cnt;
  logic       match_lock, err;
  logic [1:0] s_lt_cnt, s_gr_cnt, s_eq_cnt;
  logic       s_match_lock, s_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] l, g, e;
    logic [1:0] sl, sg, se;
    logic       lock, err;
  } exp_t;

  exp_t sb_q[$];

  int m_lt, m_gr, m_eq, m_slt, m_sgr, m_seq, m_streak;
  bit m_err;

  cmp_result_monitor #(.CNT_W(8), .STREAK_LEN(STREAK_LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .lt(lt), .gr(gr), .eq(eq),
    .clr(clr), .lt_cnt(lt_cnt), .gr_cnt(gr_cnt), .eq_cnt(eq_cnt),
    .match_lock(match_lock), .err(err)
  );

  cmp_result_monitor #(.CNT_W(2), .STREAK_LEN(STREAK_LEN)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .lt(lt), .gr(gr), .eq(eq),
    .clr(clr), .lt_cnt(s_lt_cnt), .gr_cnt(s_gr_cnt), .eq_cnt(s_eq_cnt),
    .match_lock(s_match_lock), .err(s_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lt = 0; m_gr = 0; m_eq = 0;
    m_slt = 0; m_sgr = 0; m_seq = 0;
    m_streak = 0; m_err = 0;
  endtask

  // Drive one cycle of stimulus, push the expected post-edge status, then
  // pop it and compare once the DUTs have registered the sample.
  task automatic drive(input bit v, input bit l, input bit g, input bit e, input bit c);
    exp_t x, got;
    in_valid = v; lt = l; gr = g; eq = e; clr = c;
    if (c) begin
      m_lt = 0; m_gr = 0; m_eq = 0; m_slt = 0; m_sgr = 0; m_seq = 0;
      m_streak = 0; m_err = 0;
    end else if (v) begin
      if (int'(l) + int'(g) + int'(e) != 1) m_err = 1;
      else if (l) begin
        m_lt = (m_lt < 255) ? m_lt + 1 : m_lt;
        m_slt = (m_slt < 3) ? m_slt + 1 : m_slt;
        m_streak = 0;
      end else if (g) begin
        m_gr = (m_gr < 255) ? m_gr + 1 : m_gr;
        m_sgr = (m_sgr < 3) ? m_sgr + 1 : m_sgr;
        m_streak = 0;
      end else begin
        m_eq = (m_eq < 255) ? m_eq + 1 : m_eq;
        m_seq = (m_seq < 3) ? m_seq + 1 : m_seq;
        if (m_streak < STREAK_LEN) m_streak++;
      end
    end
    x.l = 8'(m_lt); x.g = 8'(m_gr); x.e = 8'(m_eq);
    x.sl = 2'(m_slt); x.sg = 2'(m_sgr); x.se = 2'(m_seq);
    x.lock = (m_streak == STREAK_LEN);
    x.err = m_err;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0; lt = 1'b0; gr = 1'b0; eq = 1'b0; clr = 1'b0;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check("lt_cnt", 32'(lt_cnt), 32'(got.l));
      check("gr_cnt", 32'(gr_cnt), 32'(got.g));
      check("eq_cnt", 32'(eq_cnt), 32'(got.e));
      check("sat_lt_cnt", 32'(s_lt_cnt), 32'(got.sl));
      check("sat_gr_cnt", 32'(s_gr_cnt), 32'(got.sg));
      check("sat_eq_cnt", 32'(s_eq_cnt), 32'(got.se));
      check("match_lock", 32'(match_lock), 32'(got.lock));
      check("err", 32'(err), 32'(got.err));
    end
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_lt_cnt", 32'(lt_cnt), 32'd0);
    check("rst_match_lock", 32'(match_lock), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // lt (5<7), gr (10>7), eq (10==10)
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 0);
    // invalid cycle: flags ignored
    drive(0, 1, 1, 1, 0);

    // Streak: eq eq gap eq eq -> lock, eq keeps it, lt drops it
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0);
    // gr during TRACK breaks the run
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 0);

    // Illegal samples mid-run hold streak and counters; sticky err
    drive(1, 0, 0, 1, 0);
    drive(1, 1, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 1);

    // Saturation: five gr samples
    repeat (5) drive(1, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 0);

    // clr wins over a same-cycle eq
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 1);
    repeat (4) drive(1, 0, 0, 1, 0);

    // Asynchronous reset mid-run with nonzero counts
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 1, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_lt_cnt", 32'(lt_cnt), 32'd0);
    check("arst_gr_cnt", 32'(gr_cnt), 32'd0);
    check("arst_eq_cnt", 32'(eq_cnt), 32'd0);
    check("arst_match_lock", 32'(match_lock), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_sat_eq_cnt", 32'(s_eq_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
